// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: WIDTH+1 edges from accept (counting the accept edge) to out_valid; 1 edge on divide-by-zero.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake; dividend, divisor sampled at accept
//   out_valid / out_ready  result handshake; quotient, remainder, div_by_zero valid with out_valid
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // quo_q starts as the dividend and is shifted left each step: its MSB feeds
  // the partial remainder while the new quotient bit enters at the LSB.
  logic [WIDTH-1:0] quo_q;
  // The partial remainder is always < divisor after a step, so it fits in
  // WIDTH bits; the extra bit only exists in the shifted/trial values.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      dbz_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quo_q     <= '1;
              rem_q     <= dividend;
              dbz_q     <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              quo_q  <= dividend;
              rem_q  <= '0;
              dvsr_q <= divisor;
              dbz_q  <= 1'b0;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          // trial[WIDTH] set means the subtraction borrowed: restore.
          rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed vector table,
// hold / reset corner sequences, and randomized traffic against a model.
module tb_seq_divider;

  localparam int W      = 32;
  localparam int N_RAND = 1500;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int compared   = 0;
  int mismatched = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts at a negedge with the block idle; returns at the negedge after the
  // result has been retired. lat counts edges from the accept edge (=1).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'd1;
      2:       v = '1;
      3:       v = W'($urandom_range(0, 15));
      4:       v = {1'b1, 31'($urandom)};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    exp_t         pend[$];
    exp_t         e;
    int           n_acc, n_ret, cycles;
    logic         iv, ordy;
    logic [W-1:0] a, b;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0, lat: 33};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'h80000000,   q: 32'd1,          r: 32'h7FFFFFFF,   z: 1'b0, lat: 33};
    vecs[2] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          z: 1'b0, lat: 33};
    vecs[3] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd1234,       z: 1'b1, lat: 1};
    vecs[4] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0, lat: 33};
    vecs[5] = '{a: 32'd7,          b: 32'd1,          q: 32'd7,          r: 32'd0,          z: 1'b0, lat: 33};
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b0, lat: 33};
    vecs[7] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,          z: 1'b0, lat: 33};
    vecs[8] = '{a: 32'd50,         b: 32'd3,          q: 32'd16,         r: 32'd2,          z: 1'b0, lat: 33};
    vecs[9] = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b1, lat: 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      run_div(vecs[i].a, vecs[i].b, q, r, z, lat);
      chk("vec_quotient", 64'(q), 64'(vecs[i].q));
      chk("vec_remainder", 64'(r), 64'(vecs[i].r));
      chk("vec_dbz", 64'(z), 64'(vecs[i].z));
      chk("vec_latency", 64'(lat), 64'(vecs[i].lat));
    end

    // Hold in DONE with out_ready low while in_valid stays high
    in_valid  = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    dividend = 32'd999;
    divisor  = 32'd5;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'd33);
    for (int c = 0; c < 10; c++) begin
      chk("hold_result", {quotient, remainder}, {32'd14, 32'd2});
      chk("hold_handshake", {62'd0, in_ready, out_valid}, 64'b01);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("hold_release", {62'd0, in_ready, out_valid}, 64'b10);

    // Asynchronous reset in the middle of a division
    in_valid = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("midrst_held_quot", 64'(quotient), 64'd0);
    rst_n = 1'b1;
    run_div(32'd50, 32'd3, q, r, z, lat);
    chk("postrst_quotient", 64'(q), 64'd16);
    chk("postrst_remainder", 64'(r), 64'd2);
    chk("postrst_latency", 64'(lat), 64'd33);

    // Randomized traffic against a reference model
    n_acc  = 0;
    n_ret  = 0;
    cycles = 0;
    while ((n_acc < N_RAND || pend.size() != 0) && cycles < 80000) begin
      iv   = (n_acc < N_RAND) && ($urandom_range(0, 7) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a    = rnd_op();
      b    = rnd_op();
      in_valid  = iv;
      dividend  = a;
      divisor   = b;
      out_ready = ordy;
      if (in_ready && out_valid)
        chk("rand_ready_valid_excl", 64'd1, 64'd0);
      if (out_valid && ordy) begin
        if (pend.size() == 0) begin
          chk("rand_extra_result", 64'(n_ret), 64'(n_acc));
        end else begin
          e = pend.pop_front();
          n_ret++;
          chk("rand_quotient", 64'(quotient), 64'(e.q));
          chk("rand_remainder", 64'(remainder), 64'(e.r));
          chk("rand_dbz", 64'(div_by_zero), 64'(e.z));
          if (!e.z) begin
            chk("rand_identity", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
            chk("rand_rem_lt_div", 64'(remainder < e.b), 64'd1);
          end
        end
      end
      if (in_ready && iv) begin
        e.a = a;
        e.b = b;
        e.z = (b == 0);
        e.q = (b == 0) ? '1 : a / b;
        e.r = (b == 0) ? a : a % b;
        pend.push_back(e);
        n_acc++;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_all_returned", 64'(n_ret), 64'(N_RAND));
    chk("rand_pending_empty", 64'(pend.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
